// File: rtl/data_mem_arbiter_if.sv
// Core, DMA and data-memory signal bundle for data_mem_arbiter.
// slave = arbiter view; master = requesters plus the memory.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              Core_req;
    logic              Core_write;
    logic [ADDR_W-1:0] Core_addr;
    logic [DATA_W-1:0] Core_wdata;
    logic              Core_ack;
    logic [DATA_W-1:0] Core_rdata;

    logic              Dma_req;
    logic              Dma_write;
    logic [ADDR_W-1:0] Dma_addr;
    logic [DATA_W-1:0] Dma_wdata;
    logic              Dma_ack;
    logic [DATA_W-1:0] Dma_rdata;

    logic [ADDR_W-1:0] Mem_addr;
    logic [DATA_W-1:0] Mem_din;
    logic              Mem_write;
    logic [DATA_W-1:0] Mem_dout;

    modport slave (
        input  Core_req, Core_write, Core_addr, Core_wdata,
        output Core_ack, Core_rdata,
        input  Dma_req, Dma_write, Dma_addr, Dma_wdata,
        output Dma_ack, Dma_rdata,
        output Mem_addr, Mem_din, Mem_write,
        input  Mem_dout
    );

    modport master (
        output Core_req, Core_write, Core_addr, Core_wdata,
        input  Core_ack, Core_rdata,
        output Dma_req, Dma_write, Dma_addr, Dma_wdata,
        input  Dma_ack, Dma_rdata,
        input  Mem_addr, Mem_din, Mem_write,
        output Mem_dout
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between the core and the DMA engine using a
// fixed IDLE/ACCESS/WAIT/ACK sequence, with a saturating contention counter.
module data_mem_arbiter #(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 16,
    parameter bit CORE_PRIORITY = 1'b0
) (
    input  logic                Clk,
    input  logic                Rst_n,
    data_mem_arbiter_if.slave   bus,
    output logic                Busy,
    output logic                Grant_dma,
    input  logic                Stat_clr,
    output logic [15:0]         Wait_cycles
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_ACK
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_grant_dma;
    logic              r_is_write;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_din;
    logic              r_core_ack;
    logic              r_dma_ack;
    logic [DATA_W-1:0] r_core_rdata;
    logic [DATA_W-1:0] r_dma_rdata;
    logic [15:0]       r_wait_cnt;
    logic              w_any_req;
    logic              w_pick_dma;
    logic              w_lost;

    always_comb begin
        w_state_nxt = r_state;
        w_any_req   = bus.Core_req | bus.Dma_req;
        // On a tie the DMA wins only in round-robin mode and only if the core won last.
        w_pick_dma  = bus.Dma_req & (~bus.Core_req | (~CORE_PRIORITY & ~r_grant_dma));
        // In IDLE only a tie costs a cycle (for the loser); otherwise the unserved port waits.
        w_lost      = (r_state == S_IDLE) ? (bus.Core_req & bus.Dma_req)
                                          : (r_grant_dma ? bus.Core_req : bus.Dma_req);
        unique case (r_state)
            S_IDLE:   if (w_any_req) w_state_nxt = S_ACCESS;
            S_ACCESS: w_state_nxt = S_WAIT;
            S_WAIT:   w_state_nxt = S_ACK;
            S_ACK:    w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_grant_dma  <= 1'b1;
            r_is_write   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_din    <= '0;
            r_core_ack   <= 1'b0;
            r_dma_ack    <= 1'b0;
            r_core_rdata <= '0;
            r_dma_rdata  <= '0;
            r_wait_cnt   <= '0;
        end else begin
            r_mem_write <= 1'b0;
            r_core_ack  <= 1'b0;
            r_dma_ack   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant_dma <= w_pick_dma;
                        r_is_write  <= w_pick_dma ? bus.Dma_write : bus.Core_write;
                        r_mem_write <= w_pick_dma ? bus.Dma_write : bus.Core_write;
                        r_mem_addr  <= w_pick_dma ? bus.Dma_addr  : bus.Core_addr;
                        r_mem_din   <= w_pick_dma ? bus.Dma_wdata : bus.Core_wdata;
                    end
                end
                S_WAIT: begin
                    if (!r_is_write) begin
                        if (r_grant_dma) r_dma_rdata  <= bus.Mem_dout;
                        else             r_core_rdata <= bus.Mem_dout;
                    end
                    if (r_grant_dma) r_dma_ack  <= 1'b1;
                    else             r_core_ack <= 1'b1;
                end
                default: ;
            endcase
            if (Stat_clr)
                r_wait_cnt <= '0;
            else if (w_lost && (r_wait_cnt != '1))
                r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end

    assign Busy           = (r_state != S_IDLE);
    assign Grant_dma      = r_grant_dma;
    assign Wait_cycles    = r_wait_cnt;
    assign bus.Mem_addr   = r_mem_addr;
    assign bus.Mem_din    = r_mem_din;
    assign bus.Mem_write  = r_mem_write;
    assign bus.Core_ack   = r_core_ack;
    assign bus.Dma_ack    = r_dma_ack;
    assign bus.Core_rdata = r_core_rdata;
    assign bus.Dma_rdata  = r_dma_rdata;
endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port controller that shares the single-port data memory (`Data_mem`) between the core load/store unit and the DMA engine. It runs each access as a fixed four-state sequence: arbitrate, drive the memory, wait for read data, then acknowledge. It owns every memory control input and registers all of them, so the memory is only ever driven by one requester at a time. A saturating counter records cycles lost to contention.

## Interface
Parameters:
- `ADDR_W`, 8: address width, shared with `Data_mem`.
- `DATA_W`, 16: data width.
- `CORE_PRIORITY`, 0: arbitration mode. 0 = round-robin; 1 = core always wins simultaneous requests.

Ports (direction, width, meaning):
- `Clk` in 1: the single clock; all state updates on the rising edge.
- `Rst_n` in 1: asynchronous, active-low reset.
- `Core_req` in 1: core access request; held high until `Core_ack`.
- `Core_write` in 1: 1 = write, 0 = read; stable while `Core_req` is high.
- `Core_addr` in `ADDR_W`: core address; stable while `Core_req` is high.
- `Core_wdata` in `DATA_W`: core write data; stable while `Core_req` is high.
- `Core_ack` out 1: one-cycle completion pulse to the core.
- `Core_rdata` out `DATA_W`: core read data; valid from the `Core_ack` cycle and held until the next core read completes.
- `Dma_req`, `Dma_write`, `Dma_addr`, `Dma_wdata`, `Dma_ack`, `Dma_rdata`: same directions, widths and meanings for the DMA port.
- `Mem_addr` out `ADDR_W`: to `Data_mem` Address.
- `Mem_din` out `DATA_W`: to `Data_mem` Data_in.
- `Mem_write` out 1: to `Data_mem` Write.
- `Mem_dout` in `DATA_W`: from `Data_mem` Data_out; valid the cycle after the address is presented.
- `Busy` out 1: high in every state except IDLE.
- `Grant_dma` out 1: identifies the current or most recent winner; 0 = core, 1 = DMA.
- `Stat_clr` in 1: synchronous clear of `Wait_cycles`.
- `Wait_cycles` out 16: saturating count of contention cycles.

## Operation
- State machine: IDLE → ACCESS → WAIT → ACK → IDLE, with no other transitions.
- **IDLE**
  - If no request is high, remain in IDLE.
  - If exactly one request is high, grant it.
  - If both are high and `CORE_PRIORITY`=1, grant the core.
  - If both are high and `CORE_PRIORITY`=0, grant the port that did not win last; `Grant_dma` resets to 1, so the core wins the first tie.
  - On a grant, register `Mem_addr`, `Mem_din` and `Mem_write` from the winner (`Mem_write` = winner's write bit), update `Grant_dma`, and go to ACCESS.
- **ACCESS**
  - The memory sees the operation; a write commits at the end of this cycle.
  - At the next edge, `Mem_write` returns to 0 and the state goes to WAIT.
- **WAIT**
  - `Mem_dout` is valid for a read.
  - At the next edge, for a read, load the winner's `*_rdata` from `Mem_dout`.
  - At the same edge, assert the winner's `*_ack` and go to ACK.
- **ACK**
  - The ack is high for exactly this one cycle.
  - At the next edge, drop the ack and go to IDLE.
- **Requester contract**
  - A requester drops `*_req` no later than the cycle after ACK.
  - A request still high in the IDLE cycle after its own ACK is treated as a new access.
- **Read data and memory outputs**
  - A write leaves `*_rdata` unchanged.
  - The losing port's outputs never change.
  - `Mem_addr` and `Mem_din` hold their last values outside ACCESS.
- **Wait_cycles**
  - Increments by 1 in every cycle in which some `*_req` is high and that port is not the port being serviced in ACCESS, WAIT or ACK.
  - In IDLE, a cycle in which both requests are high counts once, for the loser.
  - Saturates at 0xFFFF.
  - `Stat_clr` takes priority over increment and sets the count to 0.

## Timing
- Reset values: state IDLE, all acks 0, `Mem_write` 0, `Mem_addr` 0, `Mem_din` 0, both `*_rdata` 0, `Busy` 0, `Grant_dma` 1, `Wait_cycles` 0.
- Reset is asynchronous. Asserting `Rst_n` mid-access drops `Mem_write` and every ack immediately. An aborted write may or may not have committed.
- Latency: a request seen at edge N gives ACCESS in cycle N+1, WAIT in N+2 and ack in N+3.
- Maximum throughput is one access per 4 cycles. With both ports requesting continuously in round-robin mode, grants alternate.
- Every output is registered; there is no combinational path from `*_req` to `Mem_*` or to the acks.

## Test plan
- **Core write then read:** core writes 0xBEEF to address 0x12, then reads address 0x12. Required: `Mem_write` is high exactly one cycle; `Core_ack` comes 3 cycles after the request is sampled; `Core_rdata` = 0xBEEF; `Dma_ack` never asserts.
- **Round-robin tie:** `CORE_PRIORITY`=0, both ports request from reset and hold their requests. Required: grant order is core, DMA, core, DMA; `Wait_cycles` = 4 after the first grant completes.
- **Fixed priority:** `CORE_PRIORITY`=1, the core re-requests continuously while the DMA is pending. Required: the DMA is never granted; `Wait_cycles` increments every cycle.
- **Saturation and clear:** preload `Wait_cycles` by long contention past 0xFFFF. Required: the count holds at 0xFFFF; `Stat_clr` for one cycle gives 0 on the next cycle, and `Stat_clr` wins over a simultaneous increment.
- **Reset mid-write:** assert `Rst_n` low during ACCESS of a DMA write. Required: `Mem_write`, the acks and `Busy` go to 0 asynchronously; after release, a core read of address 0x05 completes normally.
- **Read data hold:** DMA reads address 0x30 (holding 0x1234), then DMA writes 0x5555. Required: `Dma_rdata` stays 0x1234 after the write ack.
